// File: rtl/sonar_pkg.sv
// Shared types and default constants for the sweep_ranger sonar sweep controller.
package sonar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_LISTEN,
    ST_REPORT
  } state_t;

  localparam int DEF_ANGLE_WIDTH   = 8;
  localparam int DEF_SAMPLE_WIDTH  = 16;
  localparam int DEF_PERIOD_CYCLES = 16777216;
  localparam int DEF_BURST_CYCLES  = 524288;
  localparam int DEF_BLANK_CYCLES  = 600000;

  // Steering angle in degrees for a given step of the sweep.
  function automatic int step_angle(input int angle_min, input int angle_step, input int step_idx);
    return angle_min + step_idx * angle_step;
  endfunction

endpackage

// File: rtl/sweep_ranger_if.sv
// Result channel of one ping: valid/ready handshake plus the reported angle, time and hit flag.
interface sweep_ranger_if #(
    parameter int ANGLE_WIDTH = 8,
    parameter int TIME_WIDTH  = 24
);
    logic                          valid;
    logic                          ready;
    logic signed [ANGLE_WIDTH-1:0] angle;
    logic        [TIME_WIDTH-1:0]  time_cycles;
    logic                          hit;

    modport master (output valid, angle, time_cycles, hit, input ready);
    modport slave  (input valid, angle, time_cycles, hit, output ready);
endinterface

// File: rtl/echo_capture.sv
// First-crossing echo detector: strict threshold, blanking window, holds the first hit of a ping.
module echo_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int TIME_WIDTH   = 24,
    parameter int BLANK_CYCLES = 600000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    clear_in,
    input  logic                    active_in,
    input  logic [TIME_WIDTH-1:0]   count_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] threshold_in,
    output logic                    hit_out,
    output logic [TIME_WIDTH-1:0]   time_out
);

    localparam logic [TIME_WIDTH-1:0] BLANK_END = TIME_WIDTH'(BLANK_CYCLES);

    logic detect;

    assign detect = active_in && sample_valid_in && (sample_in > threshold_in)
                    && (count_in >= BLANK_END) && !hit_out;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_out  <= 1'b0;
            time_out <= '0;
        end else if (clear_in) begin
            hit_out  <= 1'b0;
            time_out <= '0;
        end else if (detect) begin
            hit_out  <= 1'b1;
            time_out <= count_in;
        end
    end

endmodule

// File: rtl/evt_counter.sv
// Free-running event counter with synchronous clear (priority) and count enable.
module evt_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)        count_out <= '0;
        else if (clear_in) count_out <= '0;
        else if (inc_in)   count_out <= count_out + WIDTH'(1);
    end

endmodule

// File: rtl/sweep_ranger.sv
// Sonar beam sweep controller: per angle, transmit a burst, listen for the first echo, report it.
module sweep_ranger
    import sonar_pkg::*;
#(
    parameter int NUM_STEPS     = 7,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_STEP    = 10,
    parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
    localparam int TIME_WIDTH   = $clog2(PERIOD_CYCLES)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          continuous_in,
    input  logic [SAMPLE_WIDTH-1:0]       threshold_in,
    input  logic [SAMPLE_WIDTH-1:0]       sample_in,
    input  logic                          sample_valid_in,
    output logic                          burst_start_out,
    output logic                          burst_active_out,
    output logic                          listen_out,
    output logic signed [ANGLE_WIDTH-1:0] angle_out,
    output logic                          result_valid_out,
    input  logic                          result_ready_in,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [TIME_WIDTH-1:0]         result_time_out,
    output logic                          result_hit_out,
    output logic                          sweep_done_out,
    output logic                          busy_out
);

    localparam int STEP_WIDTH = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [TIME_WIDTH-1:0]         BURST_LAST  = TIME_WIDTH'(BURST_CYCLES - 1);
    localparam logic [TIME_WIDTH-1:0]         PERIOD_LAST = TIME_WIDTH'(PERIOD_CYCLES - 1);
    localparam logic [STEP_WIDTH-1:0]         STEP_LAST   = STEP_WIDTH'(NUM_STEPS - 1);
    localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_FIRST = ANGLE_WIDTH'(ANGLE_MIN);

    state_t                state;
    logic [STEP_WIDTH-1:0] step;
    logic [STEP_WIDTH-1:0] next_step;
    logic [TIME_WIDTH-1:0] count;
    logic                  pinging;
    logic                  count_inc;
    logic                  handshake;
    logic                  last_step;
    logic                  go_burst;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pinging   = (state == ST_BURST) || (state == ST_LISTEN);
        count_inc = pinging && (count != PERIOD_LAST);
        handshake = result_valid_out && result_ready_in;
        last_step = (step == STEP_LAST);
        go_burst  = 1'b0;
        next_step = step;
        case (state)
            ST_IDLE: begin
                if (enable_in) begin
                    go_burst  = 1'b1;
                    next_step = '0;
                end
            end
            ST_REPORT: begin
                if (handshake && enable_in) begin
                    if (!last_step) begin
                        go_burst  = 1'b1;
                        next_step = step + STEP_WIDTH'(1);
                    end else if (continuous_in) begin
                        go_burst  = 1'b1;
                        next_step = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    evt_counter #(.WIDTH(TIME_WIDTH)) u_counter (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (go_burst),
        .inc_in    (count_inc),
        .count_out (count)
    );

    // Result time/hit come straight from the capture flops; they freeze outside BURST/LISTEN.
    echo_capture #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .TIME_WIDTH   (TIME_WIDTH),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_echo (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .clear_in        (go_burst),
        .active_in       (pinging),
        .count_in        (count),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .threshold_in    (threshold_in),
        .hit_out         (result_hit_out),
        .time_out        (result_time_out)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= ST_IDLE;
            step             <= '0;
            angle_out        <= ANGLE_FIRST;
            result_angle_out <= ANGLE_FIRST;
            burst_start_out  <= 1'b0;
            burst_active_out <= 1'b0;
            listen_out       <= 1'b0;
            result_valid_out <= 1'b0;
            sweep_done_out   <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            burst_start_out <= 1'b0;
            sweep_done_out  <= 1'b0;
            case (state)
                ST_BURST: begin
                    if (count == BURST_LAST) begin
                        state            <= ST_LISTEN;
                        burst_active_out <= 1'b0;
                        listen_out       <= 1'b1;
                    end
                end
                ST_LISTEN: begin
                    if (count == PERIOD_LAST) begin
                        state            <= ST_REPORT;
                        listen_out       <= 1'b0;
                        result_valid_out <= 1'b1;
                        result_angle_out <= angle_out;
                    end
                end
                ST_REPORT: begin
                    if (handshake) begin
                        result_valid_out <= 1'b0;
                        sweep_done_out   <= last_step;
                        state            <= ST_IDLE;
                        step             <= '0;
                        busy_out         <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Ping start overrides whatever the state branch chose above.
            if (go_burst) begin
                state            <= ST_BURST;
                step             <= next_step;
                angle_out        <= ANGLE_WIDTH'(step_angle(ANGLE_MIN, ANGLE_STEP, int'(next_step)));
                burst_start_out  <= 1'b1;
                burst_active_out <= 1'b1;
                busy_out         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sweep_ranger.sv
// Directed self-checking bench for sweep_ranger with a short 64-cycle ping and three angles.
module tb_sweep_ranger;

    localparam logic signed [7:0] A0 = -8'sd10;
    localparam logic signed [7:0] A1 = 8'sd0;
    localparam logic signed [7:0] A2 = 8'sd10;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable_in;
    logic              continuous_in;
    logic [15:0]       threshold_in;
    logic [15:0]       sample_in;
    logic              sample_valid_in;
    logic              burst_start_out;
    logic              burst_active_out;
    logic              listen_out;
    logic signed [7:0] angle_out;
    logic              sweep_done_out;
    logic              busy_out;

    int vectors = 0;
    int miscompares = 0;

    sweep_ranger_if #(.ANGLE_WIDTH(8), .TIME_WIDTH(6)) res_if ();

    sweep_ranger #(
        .NUM_STEPS(3), .ANGLE_MIN(-10), .ANGLE_STEP(10), .ANGLE_WIDTH(8), .SAMPLE_WIDTH(16),
        .PERIOD_CYCLES(64), .BURST_CYCLES(8), .BLANK_CYCLES(12)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .continuous_in    (continuous_in),
        .threshold_in     (threshold_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .burst_start_out  (burst_start_out),
        .burst_active_out (burst_active_out),
        .listen_out       (listen_out),
        .angle_out        (angle_out),
        .result_valid_out (res_if.valid),
        .result_ready_in  (res_if.ready),
        .result_angle_out (res_if.angle),
        .result_time_out  (res_if.time_cycles),
        .result_hit_out   (res_if.hit),
        .sweep_done_out   (sweep_done_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step_clk();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_burst(input int max_cycles);
        int n = 0;
        while (burst_start_out !== 1'b1 && n < max_cycles) begin
            step_clk();
            n++;
        end
        vectors++;
        if (burst_start_out !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_burst: no burst_start_out within %0d cycles", max_cycles);
        end
    endtask

    // Called at the observation point where counter==0; returns with the DUT in REPORT.
    task automatic run_ping(input logic signed [7:0] exp_angle, input int t1, input int v1,
                            input int t2, input int v2, input int drop_at);
        for (int i = 0; i < 64; i++) begin
            sample_valid_in = (i == t1) || (i == t2);
            sample_in       = (i == t1) ? 16'(v1) : ((i == t2) ? 16'(v2) : 16'd0);
            if (i == drop_at) enable_in = 1'b0;
            vectors++;
            if (angle_out !== exp_angle) begin
                miscompares++;
                $display("FAIL ping_angle c=%0d: got %0d expected %0d", i, angle_out, exp_angle);
            end
            if (i == 0 || i == 1) begin
                vectors++;
                if (burst_start_out !== (i == 0)) begin
                    miscompares++;
                    $display("FAIL burst_start c=%0d: got %0b", i, burst_start_out);
                end
            end
            if (i == 0 || i == 7 || i == 8 || i == 63) begin
                vectors++;
                if (burst_active_out !== (i < 8) || listen_out !== (i >= 8)) begin
                    miscompares++;
                    $display("FAIL gates c=%0d: burst_active=%0b listen=%0b", i, burst_active_out, listen_out);
                end
            end
            if (i == 63) begin
                vectors++;
                if (res_if.valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_valid: result_valid_out=1 at counter 63");
                end
            end
            step_clk();
        end
        sample_valid_in = 1'b0;
        sample_in       = 16'd0;
    endtask

    task automatic check_report(input logic signed [7:0] exp_angle, input logic [5:0] exp_time,
                                input logic exp_hit);
        vectors++;
        if (res_if.valid !== 1'b1 || res_if.angle !== exp_angle || res_if.time_cycles !== exp_time
            || res_if.hit !== exp_hit || burst_active_out !== 1'b0 || listen_out !== 1'b0) begin
            miscompares++;
            $display("FAIL report: got v=%0b a=%0d t=%0d h=%0b ba=%0b l=%0b expected v=1 a=%0d t=%0d h=%0b ba=0 l=0",
                     res_if.valid, res_if.angle, res_if.time_cycles, res_if.hit, burst_active_out,
                     listen_out, exp_angle, exp_time, exp_hit);
        end
    endtask

    task automatic check_start(input string name, input logic signed [7:0] exp_angle);
        vectors++;
        if (burst_start_out !== 1'b1 || angle_out !== exp_angle || busy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got start=%0b angle=%0d busy=%0b expected start=1 angle=%0d busy=1",
                     name, burst_start_out, angle_out, busy_out, exp_angle);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; enable_in = 1'b0; continuous_in = 1'b0; threshold_in = 16'd100;
        sample_in = 16'd0; sample_valid_in = 1'b0; res_if.ready = 1'b1;
        repeat (3) step_clk();
        vectors++;
        if ({busy_out, burst_start_out, burst_active_out, listen_out, res_if.valid, sweep_done_out, res_if.hit} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy_out, burst_start_out, burst_active_out, listen_out, res_if.valid, sweep_done_out, res_if.hit});
        end
        vectors++;
        if (res_if.time_cycles !== 6'd0 || angle_out !== A0 || res_if.angle !== A0) begin
            miscompares++;
            $display("FAIL reset_values: time=%0d angle=%0d res_angle=%0d expected 0 -10 -10",
                     res_if.time_cycles, angle_out, res_if.angle);
        end
        rst_in = 1'b0;
        repeat (3) step_clk();
        vectors++;
        if (busy_out !== 1'b0 || burst_start_out !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_wait: busy=%0b start=%0b expected 0 0", busy_out, burst_start_out);
        end
    endtask

    task automatic test_single_sweep();
        enable_in = 1'b1; continuous_in = 1'b0; res_if.ready = 1'b1;
        step_clk();
        wait_burst(3);
        check_start("sweep_start", A0);
        run_ping(A0, 20, 500, -1, 0, -1);
        check_report(A0, 6'd20, 1'b1);
        step_clk();
        check_start("b2b_step1", A1);
        run_ping(A1, 20, 500, -1, 0, -1);
        check_report(A1, 6'd20, 1'b1);
        step_clk();
        check_start("b2b_step2", A2);
        run_ping(A2, 20, 500, -1, 0, 5);
        check_report(A2, 6'd20, 1'b1);
        step_clk();
        vectors++;
        if (sweep_done_out !== 1'b1 || busy_out !== 1'b0 || res_if.valid !== 1'b0 || burst_start_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_end: done=%0b busy=%0b valid=%0b start=%0b expected 1 0 0 0",
                     sweep_done_out, busy_out, res_if.valid, burst_start_out);
        end
        step_clk();
        vectors++;
        if (sweep_done_out !== 1'b0 || busy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: done=%0b busy=%0b expected 0 0", sweep_done_out, busy_out);
        end
    endtask

    task automatic test_first_echo_and_drop();
        enable_in = 1'b1;
        step_clk();
        wait_burst(3);
        run_ping(A0, 10, 500, 30, 500, -1);
        check_report(A0, 6'd30, 1'b1);
        step_clk();
        check_start("second_ping", A1);
        run_ping(A1, 40, 100, -1, 0, 5);
        check_report(A1, 6'd0, 1'b0);
        step_clk();
        vectors++;
        if (busy_out !== 1'b0 || sweep_done_out !== 1'b0 || burst_start_out !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_drop: busy=%0b done=%0b start=%0b expected 0 0 0",
                     busy_out, sweep_done_out, burst_start_out);
        end
        step_clk();
        vectors++;
        if (busy_out !== 1'b0 || sweep_done_out !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_drop_idle: busy=%0b done=%0b expected 0 0", busy_out, sweep_done_out);
        end
    endtask

    task automatic test_stall_and_continuous();
        enable_in = 1'b1; continuous_in = 1'b1; res_if.ready = 1'b0;
        step_clk();
        wait_burst(3);
        run_ping(A0, 20, 500, -1, 0, -1);
        check_report(A0, 6'd20, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step_clk();
            vectors++;
            if (res_if.valid !== 1'b1 || res_if.time_cycles !== 6'd20 || res_if.angle !== A0
                || res_if.hit !== 1'b1 || burst_start_out !== 1'b0 || burst_active_out !== 1'b0) begin
                miscompares++;
                $display("FAIL stall k=%0d: v=%0b t=%0d a=%0d h=%0b start=%0b ba=%0b expected 1 20 -10 1 0 0",
                         k, res_if.valid, res_if.time_cycles, res_if.angle, res_if.hit, burst_start_out, burst_active_out);
            end
        end
        res_if.ready = 1'b1;
        step_clk();
        check_start("after_stall", A1);
        run_ping(A1, 63, 500, -1, 0, -1);
        check_report(A1, 6'd63, 1'b1);
        step_clk();
        check_start("after_late_echo", A2);
        run_ping(A2, 20, 500, -1, 0, -1);
        check_report(A2, 6'd20, 1'b1);
        step_clk();
        check_start("wrap", A0);
        vectors++;
        if (sweep_done_out !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_done: got %0b expected 1", sweep_done_out);
        end
    endtask

    task automatic test_reset_mid_ping();
        int starts = 0;
        int valids = 0;
        run_ping(A0, 20, 500, -1, 0, -1);
        check_report(A0, 6'd20, 1'b1);
        step_clk();
        check_start("pre_reset", A1);
        repeat (30) step_clk();
        rst_in = 1'b1;
        #1;
        vectors++;
        if ({busy_out, burst_start_out, burst_active_out, listen_out, res_if.valid, sweep_done_out, res_if.hit} !== 7'b0
            || angle_out !== A0 || res_if.angle !== A0 || res_if.time_cycles !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset: flags=%b angle=%0d res_angle=%0d time=%0d expected 0000000 -10 -10 0",
                     {busy_out, burst_start_out, burst_active_out, listen_out, res_if.valid, sweep_done_out, res_if.hit},
                     angle_out, res_if.angle, res_if.time_cycles);
        end
        enable_in = 1'b0;
        repeat (2) step_clk();
        rst_in = 1'b0;
        repeat (80) begin
            step_clk();
            if (burst_start_out === 1'b1) starts++;
            if (res_if.valid === 1'b1) valids++;
        end
        vectors++;
        if (starts != 0 || valids != 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: starts=%0d results=%0d expected 0 0", starts, valids);
        end
        enable_in = 1'b1;
        step_clk();
        check_start("restart", A0);
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_first_echo_and_drop();
        test_stall_and_continuous();
        test_reset_mid_ping();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
